// File: rtl/fb_port_arbiter.sv
// Shares the framebuffer RAM port between VGA scan-out (absolute priority, fixed
// 2-cycle read latency) and a processor requester served through req/ack.
module fb_port_arbiter #(
  parameter int          ADDR_W       = 18,
  parameter int          DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_q,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_starved,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {IDLE, RD1, RD2, ACK} state_t;

  state_t      state;
  state_t      state_next;
  logic        cpu_grant;
  logic [1:0]  disp_tag;
  logic [15:0] starve_cnt;
  logic [15:0] starve_cnt_next;

  // Display data is matched to its request purely by pipeline position.
  assign disp_q     = ram_q;
  assign disp_valid = disp_tag[1];
  assign cpu_ack    = (state == ACK);

  always_comb begin
    cpu_grant  = (state == IDLE) && cpu_req && !disp_req;
    state_next = state;
    case (state)
      IDLE:    if (cpu_grant) state_next = cpu_we ? ACK : RD1;
      RD1:     state_next = RD2;
      RD2:     state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!cpu_req || cpu_grant) begin
      starve_cnt_next = '0;
    end else if ((state == IDLE) && disp_req && (starve_cnt != 16'hFFFF)) begin
      starve_cnt_next = starve_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      disp_tag    <= '0;
      starve_cnt  <= '0;
      cpu_starved <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      state       <= state_next;
      disp_tag    <= {disp_tag[0], disp_req};
      starve_cnt  <= starve_cnt_next;
      cpu_starved <= (32'(starve_cnt_next) >= STARVE_LIMIT);
      // RAM output in RD2 belongs to the address issued in RD1.
      if (state == RD2) cpu_rdata <= ram_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
    end else if (disp_req) begin
      ram_addr <= disp_addr;
      ram_we   <= 1'b0;
    end else if (cpu_grant) begin
      ram_addr  <= cpu_addr;
      ram_wdata <= cpu_wdata;
      ram_we    <= cpu_we;
    end else begin
      ram_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed vector table, hand-written corner sequences
// and a randomized run against a cycle-count reference model.
module tb_fb_port_arbiter;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 8;
  localparam int LIMIT     = 8;
  localparam int RAM_DEPTH = 1 << ADDR_W;

  typedef struct {
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_q;
    logic              exp_ack;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_we;
  } vec_t;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } disp_exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic [DATA_W-1:0] disp_q;
  logic              disp_valid;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_starved;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q = '0;
  logic              ram_init = 1'b0;
  logic [DATA_W-1:0] ram_mem [0:RAM_DEPTH-1];

  int total = 0;
  int bad = 0;
  int cyc_count = 0;

  fb_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .disp_req(disp_req),
    .disp_addr(disp_addr),
    .disp_q(disp_q),
    .disp_valid(disp_valid),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .cpu_starved(cpu_starved),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we(ram_we),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_count <= cyc_count + 1;

  // Framebuffer RAM with 1-cycle synchronous read; ram_init reloads mem[a]=a[7:0].
  always @(posedge clk) begin
    if (ram_init) begin
      for (int a = 0; a < RAM_DEPTH; a++) ram_mem[a] <= 8'(a);
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
    end
    ram_q <= ram_mem[ram_addr];
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc_count);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_bit(input string name, input logic actual, input logic expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%b want=%b", name, cyc_count, actual, expected);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=0x%0h want=0x%0h", name, cyc_count, actual, expected);
    end
  endtask

  // Drives one cycle's inputs just after the rising edge and returns at the falling edge.
  task automatic apply_stimulus(input logic d_req, input logic [ADDR_W-1:0] d_addr,
                                input logic c_req, input logic c_we,
                                input logic [ADDR_W-1:0] c_addr, input logic [DATA_W-1:0] c_wdata);
    @(posedge clk);
    #1;
    disp_req  = d_req;
    disp_addr = d_addr;
    cpu_req   = c_req;
    cpu_we    = c_we;
    cpu_addr  = c_addr;
    cpu_wdata = c_wdata;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    ram_init = 1'b1;
    disp_req = 1'b0;
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
    @(posedge clk);
    #1;
    ram_init = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic vec_t make_vec(input logic dr, input int da, input logic cr, input logic cw,
                                    input int ca, input int cwd, input logic ev, input int eq,
                                    input logic ea, input int erd, input logic ew);
    vec_t v;
    v.disp_req  = dr;
    v.disp_addr = ADDR_W'(da);
    v.cpu_req   = cr;
    v.cpu_we    = cw;
    v.cpu_addr  = ADDR_W'(ca);
    v.cpu_wdata = DATA_W'(cwd);
    v.exp_valid = ev;
    v.exp_q     = DATA_W'(eq);
    v.exp_ack   = ea;
    v.exp_rdata = DATA_W'(erd);
    v.exp_we    = ew;
    return v;
  endfunction

  task automatic check_output(input string tag, input vec_t v);
    check_bit({tag, "_disp_valid"}, disp_valid, v.exp_valid);
    if (v.exp_valid) check_val({tag, "_disp_q"}, 32'(disp_q), 32'(v.exp_q));
    check_bit({tag, "_cpu_ack"}, cpu_ack, v.exp_ack);
    if (v.exp_ack) check_val({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'(v.exp_rdata));
    check_bit({tag, "_ram_we"}, ram_we, v.exp_we);
  endtask

  // Reference model: the CPU side is tracked as grant/ack/free cycle numbers, display
  // reads as a queue of (due cycle, data); CPU writes go to a region display never reads.
  task automatic run_random(input int n_cycles);
    int                m_free = 0;
    int                m_ack_cyc = -1;
    int                m_we_cyc = -1;
    int                m_cnt = 0;
    int                disp_pct = 60;
    logic              m_ack_rd = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic [DATA_W-1:0] m_mem [int];
    disp_exp_t         dq [$];
    logic              cpu_active = 1'b0;
    logic              c_we = 1'b0;
    logic [ADDR_W-1:0] c_addr = '0;
    logic [DATA_W-1:0] c_wdata = '0;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              m_idle;
    logic              exp_ack;
    logic              exp_valid;
    logic              grant;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      if (cyc % 250 == 0) begin
        case ($urandom_range(0, 2))
          0:       disp_pct = 20;
          1:       disp_pct = 60;
          default: disp_pct = 92;
        endcase
      end
      d_req  = ($urandom_range(0, 99) < disp_pct);
      d_addr = ADDR_W'($urandom_range(0, 32'h1FFFF));
      if (!cpu_active && ($urandom_range(0, 2) == 0)) begin
        cpu_active = 1'b1;
        c_we       = 1'($urandom_range(0, 1));
        c_wdata    = DATA_W'($urandom);
        if (c_we || ($urandom_range(0, 1) == 0)) c_addr = ADDR_W'(32'h20000 + $urandom_range(0, 255));
        else c_addr = ADDR_W'($urandom_range(0, RAM_DEPTH - 1));
      end
      apply_stimulus(d_req, d_addr, cpu_active, c_we, c_addr, c_wdata);

      m_idle    = (cyc >= m_free);
      exp_ack   = (cyc == m_ack_cyc);
      exp_valid = (dq.size() > 0) && (dq[0].due == cyc);
      check_bit("rnd_cpu_ack", cpu_ack, exp_ack);
      if (exp_ack && m_ack_rd) check_val("rnd_cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
      check_bit("rnd_ram_we", ram_we, cyc == m_we_cyc);
      check_bit("rnd_cpu_starved", cpu_starved, m_cnt >= LIMIT);
      check_bit("rnd_disp_valid", disp_valid, exp_valid);
      if (exp_valid) begin
        check_val("rnd_disp_q", 32'(disp_q), 32'(dq[0].data));
        void'(dq.pop_front());
      end

      grant = m_idle && cpu_active && !d_req;
      if (grant) begin
        if (c_we) begin
          m_mem[int'(c_addr)] = c_wdata;
          m_ack_cyc = cyc + 1;
          m_we_cyc  = cyc + 1;
          m_free    = cyc + 2;
          m_ack_rd  = 1'b0;
        end else begin
          m_rdata   = m_mem.exists(int'(c_addr)) ? m_mem[int'(c_addr)] : c_addr[7:0];
          m_ack_cyc = cyc + 3;
          m_free    = cyc + 4;
          m_ack_rd  = 1'b1;
        end
      end
      if (!cpu_active || grant) m_cnt = 0;
      else if (m_idle && d_req && (m_cnt < 65535)) m_cnt++;
      if (d_req) dq.push_back('{cyc + 2, d_addr[7:0]});
      if (exp_ack) cpu_active = 1'b0;
    end
  endtask

  initial begin
    vec_t vecs [$];

    // Display stream 0..9, then CPU write 0xA5 to 0x3FFFF and read it back.
    for (int i = 0; i < 10; i++) vecs.push_back(make_vec(1, i, 0, 0, 0, 0, (i >= 2), i - 2, 0, 0, 0));
    vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0));
    vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0));
    vecs.push_back(make_vec(0, 0, 1, 1, 32'h3FFFF, 8'hA5, 0, 0, 0, 0, 0));
    vecs.push_back(make_vec(0, 0, 1, 1, 32'h3FFFF, 8'hA5, 0, 0, 1, 0, 1));
    vecs.push_back(make_vec(0, 0, 1, 0, 32'h3FFFF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(make_vec(0, 0, 1, 0, 32'h3FFFF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(make_vec(0, 0, 1, 0, 32'h3FFFF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(make_vec(0, 0, 1, 0, 32'h3FFFF, 0, 0, 0, 1, 8'hA5, 0));
    vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    do_reset();
    check_val("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_bit("rst_ram_we", ram_we, 1'b0);
    check_bit("rst_disp_valid", disp_valid, 1'b0);
    check_bit("rst_cpu_ack", cpu_ack, 1'b0);
    check_bit("rst_cpu_starved", cpu_starved, 1'b0);

    for (int k = 0; k < vecs.size(); k++) begin
      apply_stimulus(vecs[k].disp_req, vecs[k].disp_addr, vecs[k].cpu_req, vecs[k].cpu_we,
                     vecs[k].cpu_addr, vecs[k].cpu_wdata);
      check_output("tbl", vecs[k]);
    end

    // Interleave: CPU read of 5 granted at n, display 7 and 8 at n+1 and n+2.
    apply_stimulus(0, 0, 1, 0, 5, 0);
    apply_stimulus(1, 7, 1, 0, 5, 0);
    apply_stimulus(1, 8, 1, 0, 5, 0);
    apply_stimulus(0, 0, 1, 0, 5, 0);
    check_output("ilv_n3", make_vec(0, 0, 0, 0, 0, 0, 1, 7, 1, 5, 0));
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("ilv_n4", make_vec(0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0));

    // Collision and starvation: display holds the port for 20 cycles.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1, ADDR_W'(100 + i), 1, 0, 18'h10, 0);
      check_bit("col_cpu_ack", cpu_ack, 1'b0);
      check_bit("col_ram_we", ram_we, 1'b0);
      check_bit("col_starved", cpu_starved, i >= LIMIT);
    end
    apply_stimulus(0, 0, 1, 0, 18'h10, 0);
    check_val("col_count", 32'(dut.starve_cnt), 32'd20);
    check_bit("col_starved_at_grant", cpu_starved, 1'b1);
    apply_stimulus(0, 0, 1, 0, 18'h10, 0);
    check_bit("col_starved_fall", cpu_starved, 1'b0);
    check_val("col_ram_addr", 32'(ram_addr), 32'h10);
    check_bit("col_ack_g1", cpu_ack, 1'b0);
    apply_stimulus(0, 0, 1, 0, 18'h10, 0);
    check_bit("col_ack_g2", cpu_ack, 1'b0);
    apply_stimulus(0, 0, 1, 0, 18'h10, 0);
    check_bit("col_ack_g3", cpu_ack, 1'b1);
    check_val("col_rdata", 32'(cpu_rdata), 32'h10);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_bit("col_ack_after", cpu_ack, 1'b0);

    // Reset asserted while a read sits in RD2.
    apply_stimulus(0, 0, 1, 0, 18'h33, 8'h5A);
    apply_stimulus(0, 0, 1, 0, 18'h33, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      reset    = 1'b0;
      disp_req = 1'b1;
      @(negedge clk);
      check_bit("rdr_cpu_ack", cpu_ack, 1'b0);
      check_bit("rdr_disp_valid", disp_valid, 1'b0);
      check_bit("rdr_ram_we", ram_we, 1'b0);
      check_bit("rdr_starved", cpu_starved, 1'b0);
      check_val("rdr_ram_addr", 32'(ram_addr), 32'd0);
      check_val("rdr_ram_wdata", 32'(ram_wdata), 32'd0);
      check_val("rdr_cpu_rdata", 32'(cpu_rdata), 32'd0);
    end
    @(posedge clk);
    #1;
    reset    = 1'b1;
    disp_req = 1'b0;
    cpu_addr = 18'h44;
    @(negedge clk);
    check_bit("rdr_rel_ack0", cpu_ack, 1'b0);
    apply_stimulus(0, 0, 1, 0, 18'h44, 0);
    check_bit("rdr_rel_ack1", cpu_ack, 1'b0);
    apply_stimulus(0, 0, 1, 0, 18'h44, 0);
    check_bit("rdr_rel_ack2", cpu_ack, 1'b0);
    apply_stimulus(0, 0, 1, 0, 18'h44, 0);
    check_bit("rdr_rel_ack3", cpu_ack, 1'b1);
    check_val("rdr_rel_rdata", 32'(cpu_rdata), 32'h44);
    apply_stimulus(0, 0, 0, 0, 0, 0);

    do_reset();
    run_random(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
